// File: rtl/spi_meas_ctrl.sv
// Command decoder between the SPI byte slave and the measurement datapath.
// Holds cycles_num, runs a measurement window and serves response bytes on MISO.
module spi_meas_ctrl #(
    parameter int               CYC_W        = 16,
    parameter logic [CYC_W-1:0] RESET_CYCLES = 16'd100,
    parameter logic [7:0]       IDLE_BYTE    = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_active,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic [7:0]       tx_byte,
    output logic [CYC_W-1:0] cycles_num,
    output logic             cycles_num_rdy,
    output logic             meas_en,
    input  logic [CYC_W-1:0] result_in,
    output logic             busy
);
    // state   | meaning
    // IDLE    | waiting for a command byte
    // WR_HI   | next byte is cycles_num high byte
    // WR_LO   | next byte is cycles_num low byte, then commit
    // RESP_HI | high response byte on MISO, next slot sends low byte
    // RESP_LO | low response byte on MISO, next slot returns to idle
    // DRAIN   | unknown command, ignore bytes until cs falls
    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RESP_HI, RESP_LO, DRAIN} state_t;

    localparam logic [7:0] CMD_WR_CYCLES = 8'h10;
    localparam logic [7:0] CMD_RD_CYCLES = 8'h20;
    localparam logic [7:0] CMD_START     = 8'h30;
    localparam logic [7:0] CMD_RD_STATUS = 8'h40;
    localparam logic [7:0] CMD_RD_RESULT = 8'h50;

    state_t           state;
    logic             cs_q;
    logic [7:0]       wr_hi;
    logic [7:0]       resp_lo;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] result_q;
    logic             err;
    logic             done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cs_q           <= 1'b0;
            tx_byte        <= IDLE_BYTE;
            cycles_num     <= RESET_CYCLES;
            cycles_num_rdy <= 1'b0;
            meas_en        <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
            done           <= 1'b0;
            result_q       <= '0;
            cnt            <= '0;
            wr_hi          <= 8'h00;
            resp_lo        <= 8'h00;
        end else begin
            cs_q           <= cs_active;
            cycles_num_rdy <= 1'b0;

            if (cs_q && !cs_active) begin
                state   <= IDLE;
                tx_byte <= IDLE_BYTE;
            end else if (cs_active && rx_valid) begin
                case (state)
                    IDLE: begin
                        case (rx_byte)
                            CMD_WR_CYCLES: state <= WR_HI;
                            CMD_RD_CYCLES: begin
                                tx_byte <= cycles_num[15:8];
                                resp_lo <= cycles_num[7:0];
                                state   <= RESP_HI;
                            end
                            CMD_RD_RESULT: begin
                                tx_byte <= result_q[15:8];
                                resp_lo <= result_q[7:0];
                                state   <= RESP_HI;
                            end
                            CMD_RD_STATUS: begin
                                tx_byte <= {5'b0, err, done, busy};
                                err     <= 1'b0;
                                done    <= 1'b0;
                                state   <= RESP_LO;
                            end
                            CMD_START: begin
                                if (!busy && cycles_num != '0) begin
                                    cnt     <= cycles_num;
                                    busy    <= 1'b1;
                                    meas_en <= 1'b1;
                                    done    <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                                state <= IDLE;
                            end
                            default: begin
                                err   <= 1'b1;
                                state <= DRAIN;
                            end
                        endcase
                    end
                    WR_HI: begin
                        wr_hi <= rx_byte;
                        state <= WR_LO;
                    end
                    WR_LO: begin
                        cycles_num     <= {wr_hi, rx_byte};
                        cycles_num_rdy <= 1'b1;
                        state          <= IDLE;
                    end
                    RESP_HI: begin
                        tx_byte <= resp_lo;
                        state   <= RESP_LO;
                    end
                    RESP_LO: begin
                        tx_byte <= IDLE_BYTE;
                        state   <= IDLE;
                    end
                    default: state <= DRAIN;
                endcase
            end

            // Window end comes last so a done set here beats a status-read clear.
            if (meas_en) begin
                if (cnt == CYC_W'(1)) begin
                    meas_en  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    result_q <= result_in;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt - CYC_W'(1);
                end
            end
        end
    end
endmodule
